// File: rtl/pool_window_buffer_if.sv
// Handshake bundle between the pixel source, the window former and the pooling stage.
// The slave side is the window former; the master side is its surrounding environment.
interface pool_window_buffer_if;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] pool_out;
  logic       frame_done;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, pool_out, frame_done
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, pool_out, frame_done
  );
endinterface

// File: rtl/pool_window_buffer.sv
// Streaming 2x2 stride-2 window former: buffers the even row of each row pair and
// emits one 4-bit window per odd-row odd-column pixel to the binarized max-pool stage.
module pool_window_buffer #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pool_window_buffer_if.slave  bus
);

  localparam int unsigned CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

  typedef enum logic {
    EVEN_ROW = 1'b0,
    ODD_ROW  = 1'b1
  } phase_e;

  phase_e           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [IMG_W-1:0] lb_q, lb_d;
  logic             left_q, left_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [3:0]       pool_q, pool_d;

  logic             in_ready;
  logic             accept;
  logic             col_last;
  logic             row_last;

  // No skid buffer: a new pixel may enter only if the output slot is free or draining.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.pool_out   = pool_q;
  assign bus.frame_done = frame_done_q;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    lb_d         = lb_q;
    left_d       = left_q;
    out_valid_d  = out_valid_q && !bus.out_ready;
    pool_d       = pool_q;
    frame_done_d = 1'b0;

    if (accept) begin
      col_d = col_last ? '0 : CW'(col_q + CW'(1));
      if (col_last) begin
        row_d   = row_last ? '0 : RW'(row_q + RW'(1));
        state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
      end

      case (state_q)
        EVEN_ROW: lb_d[col_q] = bus.in_bit;
        ODD_ROW: begin
          if (!col_q[0]) begin
            left_d = bus.in_bit;
          end else begin
            // Bottom-right pixel completes the window; it may replace one draining this cycle.
            out_valid_d  = 1'b1;
            pool_d       = {bus.in_bit, left_q, lb_q[col_q], lb_q[CW'(col_q - CW'(1))]};
            frame_done_d = row_last && col_last;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EVEN_ROW;
      col_q        <= '0;
      row_q        <= '0;
      left_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pool_q       <= 4'b0000;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      left_q       <= left_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      pool_q       <= pool_d;
    end
  end

  // Line buffer needs no reset: each entry is rewritten on the even row before use.
  always_ff @(posedge clk) begin
    lb_q <= lb_d;
  end

endmodule

// File: tb/tb_pool_window_buffer.sv
// Randomized bench for pool_window_buffer (4x4 frames) against a pixel-array reference model.
module tb_pool_window_buffer;

  localparam int unsigned W    = 4;
  localparam int unsigned H    = 4;
  localparam int unsigned NPIX = W * H;

  typedef struct packed {
    logic [3:0] win;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pool_window_buffer_if bus ();

  pool_window_buffer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   n_win    = 0;
  int   n_fd     = 0;
  int   idx      = 0;
  bit   ready_rand = 1'b0;
  bit   pix [NPIX];
  exp_t exp_q [$];
  int   lat_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (ready_rand) bus.out_ready = ($urandom_range(99) < 70);
  end

  // Reference: store the frame as a 2-D pixel array; a window is due at every odd/odd pixel.
  task automatic model_accept(input bit b, input int acc_cyc);
    int   r;
    int   c;
    exp_t e;
    r = idx / W;
    c = idx % W;
    pix[idx] = b;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      e.win = {pix[r*W + c], pix[r*W + c - 1], pix[(r-1)*W + c], pix[(r-1)*W + c - 1]};
      e.fd  = (idx == NPIX - 1);
      exp_q.push_back(e);
      lat_q.push_back(acc_cyc);
    end
    idx = (idx + 1) % NPIX;
  endtask

  task automatic push(input bit b, input int gap_pct);
    bit acc     = 1'b0;
    int acc_cyc = 0;
    int tries   = 0;
    while (!acc) begin
      bus.in_valid = ($urandom_range(99) >= gap_pct);
      bus.in_bit   = bus.in_valid ? b : 1'($urandom_range(1));
      @(negedge clk);
      acc     = bus.in_valid && bus.in_ready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      tries++;
      if (!acc && tries > 200) begin
        chk("accept_timeout", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    model_accept(b, acc_cyc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    idx = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
    chk({tag, "_pool_out"},   32'(bus.pool_out),   32'd0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: each newly presented window is matched against the model queue.
  bit         prev_valid = 1'b0;
  bit         prev_hs    = 1'b0;
  logic [3:0] last_pool  = 4'b0;
  exp_t       me;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      chk("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid) begin
        if (!prev_valid || prev_hs) begin
          n_win++;
          if (bus.frame_done) n_fd++;
          if (exp_q.size() == 0) begin
            chk("unexpected_window", 32'(exp_q.size()), 32'd1);
          end else begin
            me = exp_q.pop_front();
            chk("pool_out",   32'(bus.pool_out),   32'(me.win));
            chk("frame_done", 32'(bus.frame_done), 32'(me.fd));
            chk("latency",    32'(cyc),            32'(lat_q.pop_front() + 1));
          end
        end else begin
          chk("hold_pool_out",   32'(bus.pool_out),   32'(last_pool));
          chk("frame_done_held", 32'(bus.frame_done), 32'd0);
        end
      end else begin
        chk("frame_done_idle", 32'(bus.frame_done), 32'd0);
      end
      prev_valid = bus.out_valid;
      prev_hs    = bus.out_valid && bus.out_ready;
      last_pool  = bus.pool_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ord [NPIX];
    int w0;
    int f0;
    int c0;
    ord = '{1,0,1,0, 0,1,1,0, 1,1,1,1, 0,0,0,0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("init");

    // Mid-stream reset while a window is held by backpressure.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(1'($urandom_range(1)), 0);
    chk("pending_before_reset", 32'(bus.out_valid), 32'd1);
    do_reset();
    check_reset_state("mid_reset");
    bus.out_ready = 1'b1;

    w0 = n_win;
    for (int i = 0; i < NPIX; i++) push(1'b1, 0);
    drain();
    chk("ones_window_count", 32'(n_win - w0), 32'd4);

    w0 = n_win;
    f0 = n_fd;
    for (int i = 0; i < NPIX; i++) push(ord[i], 0);
    drain();
    chk("order_window_count", 32'(n_win - w0), 32'd4);
    chk("order_fd_count",     32'(n_fd - f0),  32'd1);

    c0 = cyc;
    for (int i = 0; i < NPIX; i++) push(1'($urandom_range(1)), 0);
    chk("throughput_cycles", 32'(cyc - c0), 32'(NPIX));
    drain();

    // Stall the consumer for 5 cycles on the first window of a frame.
    w0 = n_win;
    fork
      begin
        for (int i = 0; i < NPIX; i++) push(1'($urandom_range(1)), 0);
      end
      begin
        int k = 0;
        logic [3:0] held;
        while (!bus.out_valid && k < 100) begin
          @(posedge clk);
          #1;
          k++;
        end
        chk("bp_window_seen", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b0;
        held = bus.pool_out;
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
          chk("bp_pool_out", 32'(bus.pool_out), 32'(held));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_window_count", 32'(n_win - w0), 32'd4);

    w0 = n_win;
    f0 = n_fd;
    for (int i = 0; i < 2 * NPIX; i++) push(1'($urandom_range(1)), 0);
    drain();
    chk("b2b_window_count", 32'(n_win - w0), 32'd8);
    chk("b2b_fd_count",     32'(n_fd - f0),  32'd2);

    // Input gaps plus random consumer backpressure over several frames.
    w0 = n_win;
    f0 = n_fd;
    ready_rand = 1'b1;
    for (int i = 0; i < 3 * NPIX; i++) push(1'($urandom_range(1)), 30);
    drain();
    ready_rand = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();
    chk("gap_window_count", 32'(n_win - w0), 32'd12);
    chk("gap_fd_count",     32'(n_fd - f0),  32'd3);

    repeat (3) @(posedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
